glip_channel_deserializer: RTL



---
 rtl/glip_channel_deserializer.sv | 118 +++++++++++
 1 files changed

// File: rtl/glip_channel_deserializer.sv
// Width up-converter: packs RATIO narrow glip_channel words into one wide word.
// Optional GLIP_DESER_FLUSH_EN adds a flush input that emits a partial word, tagged by out_nwords.
module glip_channel_deserializer #(
    parameter  int WIDTH_IN  = 16,
    parameter  int RATIO     = 4,
    localparam int WIDTH_OUT = WIDTH_IN * RATIO
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH_IN-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH_OUT-1:0]       out_data,
    output logic                       out_valid,
`ifdef GLIP_DESER_FLUSH_EN
    input  logic                       flush,
    output logic [$clog2(RATIO+1)-1:0] out_nwords,
`endif
    input  logic                       out_ready
);

    localparam int CW  = $clog2(RATIO);
    localparam int NW  = $clog2(RATIO+1);
    localparam int ACW = WIDTH_IN * (RATIO - 1);

    logic [ACW-1:0]       acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept;
    logic                 full;
    logic                 load;
    logic [WIDTH_OUT-1:0] packed_word;

    // The last slot can only be taken when the output register is free to load it.
    assign in_ready = (count_q != CW'(RATIO - 1)) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign full     = accept && (count_q == CW'(RATIO - 1));

`ifdef GLIP_DESER_FLUSH_EN
    logic [NW-1:0]        nwords_q, nwords_d;
    logic [NW-1:0]        eff_count;
    logic                 fire;
    logic [WIDTH_OUT-1:0] acc_ext;

    assign eff_count  = NW'(count_q) + NW'(accept);
    assign fire       = flush && (eff_count != '0) && (!out_valid_q || out_ready);
    assign load       = full || fire;
    assign acc_ext    = {{WIDTH_IN{1'b0}}, acc_q};
    assign out_nwords = nwords_q;

    // Slots beyond the held words read as zero, since the accumulator keeps stale data.
    always_comb begin
        packed_word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(count_q))
                packed_word[i*WIDTH_IN +: WIDTH_IN] = acc_ext[i*WIDTH_IN +: WIDTH_IN];
            else if ((i == int'(count_q)) && accept)
                packed_word[i*WIDTH_IN +: WIDTH_IN] = in_data;
        end
    end
`else
    assign load        = full;
    assign packed_word = {in_data, acc_q};
`endif

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef GLIP_DESER_FLUSH_EN
        nwords_d    = nwords_q;
`endif
        if (load) begin
            out_data_d  = packed_word;
            out_valid_d = 1'b1;
            count_d     = '0;
`ifdef GLIP_DESER_FLUSH_EN
            nwords_d    = eff_count;
`endif
        end else begin
            if (out_valid_q && out_ready)
                out_valid_d = 1'b0;
            if (accept) begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (count_q == CW'(i))
                        acc_d[i*WIDTH_IN +: WIDTH_IN] = in_data;
                end
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef GLIP_DESER_FLUSH_EN
            nwords_q    <= '0;
`endif
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef GLIP_DESER_FLUSH_EN
            nwords_q    <= nwords_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
